// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control FSM: state encodings,
// opcode constants, ULA operation codes, mux select codes and the control word.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDI_EXEC = 4'd10,
    S_ADDI_WB   = 4'd11,
    S_HALT      = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [1:0] ULA_ADD   = 2'b00;
  localparam logic [1:0] ULA_SUB   = 2'b01;
  localparam logic [1:0] ULA_FUNCT = 2'b10;

  localparam logic [1:0] SRC_B_REG      = 2'b00;
  localparam logic [1:0] SRC_B_FOUR     = 2'b01;
  localparam logic [1:0] SRC_B_IMM      = 2'b10;
  localparam logic [1:0] SRC_B_IMM_SHL2 = 2'b11;

  localparam logic [1:0] PC_SRC_ULA    = 2'b00;
  localparam logic [1:0] PC_SRC_ULAOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  // Every datapath control produced for one state in one cycle.
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] ula_operation;
    logic [1:0] pc_source;
    logic       instr_done;
  } ctrl_word_t;

endpackage

// File: rtl/mips_ctrl_decode.sv
// Combinational state-to-control-word decoder for the multi-cycle MIPS FSM.
// The JUMP control word exists only when MIPS_CTRL_JUMP_EN is defined.
module mips_ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  state_t     state,
  input  logic       mem_ready,
  output ctrl_word_t ctrl
);

  // Moore decode of the current state; memory strobes that complete a phase wait on mem_ready.
  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read      = 1'b1;
        ctrl.alu_src_b     = SRC_B_FOUR;
        ctrl.ula_operation = ULA_ADD;
        ctrl.pc_source     = PC_SRC_ULA;
        ctrl.ir_write      = mem_ready;
        ctrl.pc_write      = mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_b     = SRC_B_IMM_SHL2;
        ctrl.ula_operation = ULA_ADD;
      end
      S_MEM_ADDR: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRC_B_IMM;
        ctrl.ula_operation = ULA_ADD;
      end
      S_MEM_READ: begin
        ctrl.i_or_d   = 1'b1;
        ctrl.mem_read = 1'b1;
      end
      S_MEM_WRITE: begin
        ctrl.i_or_d     = 1'b1;
        ctrl.mem_write  = 1'b1;
        ctrl.instr_done = mem_ready;
      end
      S_MEM_WB: begin
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_R_EXEC: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRC_B_REG;
        ctrl.ula_operation = ULA_FUNCT;
      end
      S_R_WB: begin
        ctrl.reg_dst    = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_ADDI_EXEC: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRC_B_IMM;
        ctrl.ula_operation = ULA_ADD;
      end
      S_ADDI_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRC_B_REG;
        ctrl.ula_operation = ULA_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PC_SRC_ULAOUT;
        ctrl.instr_done    = 1'b1;
      end
`ifdef MIPS_CTRL_JUMP_EN
      S_JUMP: begin
        ctrl.pc_write   = 1'b1;
        ctrl.pc_source  = PC_SRC_JUMP;
        ctrl.instr_done = 1'b1;
      end
`endif
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multi-cycle MIPS control FSM: state register, next-state logic, sticky
// illegal-opcode flag and reset gating of all strobes.
// Optional feature macro: MIPS_CTRL_JUMP_EN (builds the JUMP state for opcode 0x02).
module mips_multicycle_control
  import mips_ctrl_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] ula_operation,
  output logic [1:0] pc_source,
  output logic       instr_done,
  output logic       illegal_op,
  output logic [3:0] state
);

  state_t     state_q;
  logic       illegal_q;
  ctrl_word_t ctrl;

  mips_ctrl_decode u_decode (
    .state     (state_q),
    .mem_ready (mem_ready),
    .ctrl      (ctrl)
  );

  // State sequencing; entering HALT from any path sets the sticky illegal flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      case (state_q)
        S_FETCH:     if (mem_ready) state_q <= S_DECODE;
        S_DECODE: begin
          case (opcode)
            OP_LW, OP_SW: state_q <= S_MEM_ADDR;
            OP_RTYPE:     state_q <= S_R_EXEC;
            OP_BEQ:       state_q <= S_BRANCH;
            OP_ADDI:      state_q <= S_ADDI_EXEC;
`ifdef MIPS_CTRL_JUMP_EN
            OP_J:         state_q <= S_JUMP;
`endif
            default: begin
              state_q   <= S_HALT;
              illegal_q <= 1'b1;
            end
          endcase
        end
        S_MEM_ADDR: begin
          if (opcode == OP_LW) begin
            state_q <= S_MEM_READ;
          end else if (opcode == OP_SW) begin
            state_q <= S_MEM_WRITE;
          end else begin
            state_q   <= S_HALT;
            illegal_q <= 1'b1;
          end
        end
        S_MEM_READ:  if (mem_ready) state_q <= S_MEM_WB;
        S_MEM_WRITE: if (mem_ready) state_q <= S_FETCH;
        S_MEM_WB:    state_q <= S_FETCH;
        S_R_EXEC:    state_q <= S_R_WB;
        S_R_WB:      state_q <= S_FETCH;
        S_ADDI_EXEC: state_q <= S_ADDI_WB;
        S_ADDI_WB:   state_q <= S_FETCH;
        S_BRANCH:    state_q <= S_FETCH;
`ifdef MIPS_CTRL_JUMP_EN
        S_JUMP:      state_q <= S_FETCH;
`endif
        S_HALT:      state_q <= S_HALT;
        default: begin
          state_q   <= S_HALT;
          illegal_q <= 1'b1;
        end
      endcase
    end
  end

  // Strobes are suppressed for the whole reset cycle; mux selects pass straight through.
  always_comb begin
    pc_write      = ctrl.pc_write      & ~reset;
    pc_write_cond = ctrl.pc_write_cond & ~reset;
    mem_read      = ctrl.mem_read      & ~reset;
    mem_write     = ctrl.mem_write     & ~reset;
    ir_write      = ctrl.ir_write      & ~reset;
    reg_write     = ctrl.reg_write     & ~reset;
    instr_done    = ctrl.instr_done    & ~reset;
    i_or_d        = ctrl.i_or_d;
    mem_to_reg    = ctrl.mem_to_reg;
    reg_dst       = ctrl.reg_dst;
    alu_src_a     = ctrl.alu_src_a;
    alu_src_b     = ctrl.alu_src_b;
    ula_operation = ctrl.ula_operation;
    pc_source     = ctrl.pc_source;
    illegal_op    = illegal_q;
    state         = state_q;
  end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Scoreboard bench for mips_multicycle_control: the stimulus walks each
// instruction through its expected phases, pushing one expected control
// record per cycle; a negedge monitor pops and compares against the DUT.
module tb_mips_multicycle_control;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = 6'h00;
  logic       mem_ready = 1'b0;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0] alu_src_b, ula_operation, pc_source;
  logic       instr_done, illegal_op;
  logic [3:0] state;

  typedef struct {
    string       name;
    logic        rst;
    logic [21:0] vec;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clock = ~clock;

  mips_multicycle_control dut (
    .clock         (clock),
    .reset         (reset),
    .opcode        (opcode),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .i_or_d        (i_or_d),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .mem_to_reg    (mem_to_reg),
    .reg_dst       (reg_dst),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .ula_operation (ula_operation),
    .pc_source     (pc_source),
    .instr_done    (instr_done),
    .illegal_op    (illegal_op),
    .state         (state)
  );

  function automatic logic [21:0] pack_word(
    logic [3:0] st, logic pw, logic pwc, logic iod, logic mr, logic mw,
    logic irw, logic m2r, logic rd, logic rw, logic asa,
    logic [1:0] asb, logic [1:0] uo, logic [1:0] ps, logic done, logic ill);
    return {st, pw, pwc, iod, mr, mw, irw, m2r, rd, rw, asa, asb, uo, ps, done, ill};
  endfunction

  // Expected control word for one cycle of an instruction phase.
  function automatic exp_t step(string name, int st, logic rdy);
    exp_t e;
    e.name = name;
    e.rst  = 1'b0;
    case (st)
      0:  e.vec = pack_word(4'd0,  rdy,0,0,1,0,rdy,0,0,0,0, 2'b01,2'b00,2'b00, 0,0);
      1:  e.vec = pack_word(4'd1,  0,0,0,0,0,0,0,0,0,0,     2'b11,2'b00,2'b00, 0,0);
      2:  e.vec = pack_word(4'd2,  0,0,0,0,0,0,0,0,0,1,     2'b10,2'b00,2'b00, 0,0);
      3:  e.vec = pack_word(4'd3,  0,0,1,1,0,0,0,0,0,0,     2'b00,2'b00,2'b00, 0,0);
      4:  e.vec = pack_word(4'd4,  0,0,0,0,0,0,1,0,1,0,     2'b00,2'b00,2'b00, 1,0);
      5:  e.vec = pack_word(4'd5,  0,0,1,0,1,0,0,0,0,0,     2'b00,2'b00,2'b00, rdy,0);
      6:  e.vec = pack_word(4'd6,  0,0,0,0,0,0,0,0,0,1,     2'b00,2'b10,2'b00, 0,0);
      7:  e.vec = pack_word(4'd7,  0,0,0,0,0,0,0,1,1,0,     2'b00,2'b00,2'b00, 1,0);
      8:  e.vec = pack_word(4'd8,  0,1,0,0,0,0,0,0,0,1,     2'b00,2'b01,2'b01, 1,0);
      9:  e.vec = pack_word(4'd9,  1,0,0,0,0,0,0,0,0,0,     2'b00,2'b00,2'b10, 1,0);
      10: e.vec = pack_word(4'd10, 0,0,0,0,0,0,0,0,0,1,     2'b10,2'b00,2'b00, 0,0);
      11: e.vec = pack_word(4'd11, 0,0,0,0,0,0,0,0,1,0,     2'b00,2'b00,2'b00, 1,0);
      default: e.vec = pack_word(4'd15, 0,0,0,0,0,0,0,0,0,0, 2'b00,2'b00,2'b00, 0,1);
    endcase
    return e;
  endfunction

  // Drive one cycle of inputs and queue what the DUT must show during it.
  task automatic applyStimulus(exp_t e, logic rdy, logic rst);
    mem_ready = rdy;
    reset     = rst;
    e.rst     = rst;
    if (rst) e.vec = '0;
    exp_q.push_back(e);
    @(posedge clock);
    #1;
  endtask

  task automatic resetCycle(string name);
    exp_t e;
    e.name = name;
    e.vec  = '0;
    applyStimulus(e, 1'($urandom_range(0, 1)), 1'b1);
  endtask

  function automatic bit is_legal(logic [5:0] op);
    bit legal;
    legal = (op == 6'h00) || (op == 6'h23) || (op == 6'h2B) || (op == 6'h04) || (op == 6'h08);
`ifdef MIPS_CTRL_JUMP_EN
    legal = legal || (op == 6'h02);
`endif
    return legal;
  endfunction

  // Stay halted for a few cycles regardless of opcode, then a reset pulse.
  task automatic haltAndRecover(int n);
    for (int i = 0; i < n; i++) begin
      opcode = 6'($urandom_range(0, 63));
      applyStimulus(step("halt", 15, 1'b0), 1'($urandom_range(0, 1)), 1'b0);
    end
    resetCycle("halt_reset");
  endtask

  // One whole instruction: fw fetch wait cycles and mw memory wait cycles.
  task automatic runInstr(logic [5:0] op, int fw, int mw);
    opcode = op;
    for (int i = 0; i < fw; i++) applyStimulus(step("fetch_wait", 0, 1'b0), 1'b0, 1'b0);
    applyStimulus(step("fetch_ready", 0, 1'b1), 1'b1, 1'b0);
    applyStimulus(step("decode", 1, 1'b0), 1'($urandom_range(0, 1)), 1'b0);
    if (!is_legal(op)) begin
      haltAndRecover(1 + int'($urandom_range(0, 2)));
    end else begin
      case (op)
        6'h00: begin
          applyStimulus(step("r_exec", 6, 1'b0), 1'($urandom_range(0, 1)), 1'b0);
          applyStimulus(step("r_wb", 7, 1'b0), 1'($urandom_range(0, 1)), 1'b0);
        end
        6'h08: begin
          applyStimulus(step("addi_exec", 10, 1'b0), 1'($urandom_range(0, 1)), 1'b0);
          applyStimulus(step("addi_wb", 11, 1'b0), 1'($urandom_range(0, 1)), 1'b0);
        end
        6'h23: begin
          applyStimulus(step("mem_addr", 2, 1'b0), 1'($urandom_range(0, 1)), 1'b0);
          for (int i = 0; i < mw; i++) applyStimulus(step("lw_wait", 3, 1'b0), 1'b0, 1'b0);
          applyStimulus(step("lw_ready", 3, 1'b1), 1'b1, 1'b0);
          applyStimulus(step("mem_wb", 4, 1'b0), 1'($urandom_range(0, 1)), 1'b0);
        end
        6'h2B: begin
          applyStimulus(step("mem_addr", 2, 1'b0), 1'($urandom_range(0, 1)), 1'b0);
          for (int i = 0; i < mw; i++) applyStimulus(step("sw_wait", 5, 1'b0), 1'b0, 1'b0);
          applyStimulus(step("sw_ready", 5, 1'b1), 1'b1, 1'b0);
        end
        6'h04: applyStimulus(step("branch", 8, 1'b0), 1'($urandom_range(0, 1)), 1'b0);
        default: applyStimulus(step("jump", 9, 1'b0), 1'($urandom_range(0, 1)), 1'b0);
      endcase
    end
  endtask

  // Compare each queued expectation against the DUT on the falling edge.
  task automatic checkOutput();
    exp_t        e;
    logic [21:0] act, mask;
    e    = exp_q.pop_front();
    act  = pack_word(state, pc_write, pc_write_cond, i_or_d, mem_read, mem_write,
                     ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a,
                     alu_src_b, ula_operation, pc_source, instr_done, illegal_op);
    mask = e.rst ? pack_word(4'd0, 1,1,0,1,1,1,0,0,1,0, 2'b00,2'b00,2'b00, 1,0) : '1;
    n_cmp++;
    if ((act & mask) !== (e.vec & mask)) begin
      n_err++;
      $display("[TB] FAIL %s: got %h want %h (state %0d)", e.name, act & mask, e.vec & mask, state);
    end
  endtask

  always @(negedge clock) begin
    if (exp_q.size() > 0) checkOutput();
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    logic [5:0] ops[6];
    logic [5:0] op;
    ops[0] = 6'h00; ops[1] = 6'h23; ops[2] = 6'h2B;
    ops[3] = 6'h04; ops[4] = 6'h08; ops[5] = 6'h02;
    @(posedge clock);
    #1;
    resetCycle("reset0");
    resetCycle("reset1");

    runInstr(6'h00, 0, 0);
    runInstr(6'h23, 0, 2);
    runInstr(6'h04, 0, 0);
    runInstr(6'h00, 3, 0);
    runInstr(6'h2B, 1, 1);
    runInstr(6'h08, 0, 0);
    runInstr(6'h3F, 0, 0);
    runInstr(6'h02, 0, 0);
    runInstr(6'h04, 0, 0);

    opcode = 6'h23;
    applyStimulus(step("abort_fetch", 0, 1'b1), 1'b1, 1'b0);
    applyStimulus(step("abort_decode", 1, 1'b0), 1'b0, 1'b0);
    applyStimulus(step("abort_mem_addr", 2, 1'b0), 1'b1, 1'b0);
    resetCycle("abort_reset");
    runInstr(6'h2B, 0, 0);

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        do op = 6'($urandom_range(0, 63)); while (is_legal(op));
      end else begin
        op = ops[$urandom_range(0, 5)];
      end
      runInstr(op, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
    end

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clock);
    if (exp_q.size() > 0) begin
      n_err++;
      $display("[TB] FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_control.md
# mips_multicycle_control

Multi-cycle control FSM for the MIPS datapath: the PC, instruction/data memory, regfile, ULA, sign-extend and muxes are shared across several cycles per instruction, and this block sequences them. It decodes the opcode latched in the instruction register and drives every mux select, write strobe and ALU-operation code the datapath needs. It supports memory wait states through a ready handshake and halts on an illegal opcode.

## Interface
Parameters:
- none

Ports:
- clock  in  1  system clock; all state changes on the rising edge
- reset  in  1  synchronous, active-high reset
- opcode  in  6  instruction[31:26] from the instruction register
- mem_ready  in  1  memory has completed the current read or write this cycle
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load when ula zero flag = 1 (datapath ANDs it)
- i_or_d  out  1  memory address select: 0 = PC, 1 = ULA result register
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  load the instruction register
- mem_to_reg  out  1  regfile write data: 0 = ULA out, 1 = memory data register
- reg_dst  out  1  write register: 0 = instr[20:16], 1 = instr[15:11]
- reg_write  out  1  regfile write enable
- alu_src_a  out  1  ULA In1: 0 = PC, 1 = register A
- alu_src_b  out  2  ULA In2: 00 = register B, 01 = constant 4, 10 = sign-extended imm, 11 = sign-extended imm << 2
- ula_operation  out  2  to ula_control: 00 = add, 01 = sub, 10 = funct field
- pc_source  out  2  next PC: 00 = ULA result, 01 = ULA out register (branch target), 10 = jump target
- instr_done  out  1  one-cycle pulse in an instruction's final cycle
- illegal_op  out  1  sticky: unsupported opcode decoded
- state  out  4  current FSM state (debug)

## Operation
- Opcodes: R-type 0x00, LW 0x23, SW 0x2B, BEQ 0x04, ADDI 0x08, J 0x02.
- States/encodings: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_READ 3, MEM_WB 4, MEM_WRITE 5, R_EXEC 6, R_WB 7, BRANCH 8, JUMP 9, ADDI_EXEC 10, ADDI_WB 11, HALT 15.
- FETCH: i_or_d=0, mem_read=1, alu_src_a=0, alu_src_b=01, ula_operation=00, pc_source=00. ir_write=pc_write=1 only when mem_ready=1, then go to DECODE. Otherwise stay in FETCH.
- DECODE: alu_src_a=0, alu_src_b=11, ula_operation=00 (branch target precompute). Next state is selected by opcode: LW/SW to MEM_ADDR, R to R_EXEC, BEQ to BRANCH, J to JUMP, ADDI to ADDI_EXEC, anything else to HALT.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, ula_operation=00. LW goes to MEM_READ, SW goes to MEM_WRITE.
- MEM_READ / MEM_WRITE: i_or_d=1, with mem_read or mem_write held high until mem_ready=1. MEM_READ then goes to MEM_WB. MEM_WRITE completes (instr_done=1 on its ready cycle) and goes to FETCH.
- MEM_WB: reg_dst=0, mem_to_reg=1, reg_write=1, instr_done=1, then FETCH.
- R_EXEC: alu_src_a=1, alu_src_b=00, ula_operation=10, then R_WB. R_WB: reg_dst=1, mem_to_reg=0, reg_write=1, instr_done=1, then FETCH.
- ADDI_EXEC: alu_src_a=1, alu_src_b=10, ula_operation=00, then ADDI_WB. ADDI_WB: reg_dst=0, mem_to_reg=0, reg_write=1, instr_done=1, then FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, ula_operation=01, pc_write_cond=1, pc_source=01, instr_done=1, then FETCH.
- JUMP: pc_write=1, pc_source=10, instr_done=1, then FETCH.
- HALT: illegal_op=1, all strobes 0. Stays in HALT until reset.
- Unlisted outputs in any state are 0.

## Timing
- Moore outputs are decoded from the state register. The only exception is FETCH/MEM_* strobes, which are gated by mem_ready.
- Reset: on the edge with reset=1, state becomes FETCH and illegal_op clears. While reset=1, every strobe is forced to 0 (pc_write, pc_write_cond, ir_write, reg_write, mem_read, mem_write, instr_done).
- Reset mid-instruction abandons the instruction. No strobe is issued in the reset cycle.
- Cycles per instruction with mem_ready held at 1: R 4, ADDI 4, SW 4, LW 5, BEQ 3, J 3. Each wait cycle with mem_ready=0 adds one cycle in FETCH, MEM_READ or MEM_WRITE.
- mem_ready is ignored outside FETCH, MEM_READ and MEM_WRITE.

## Configuration
- MIPS_CTRL_JUMP_EN defined: opcode 0x02 goes to JUMP as described.
- MIPS_CTRL_JUMP_EN undefined: the JUMP state is not built, opcode 0x02 is illegal (goes to HALT), and pc_source never drives 10.

## Structure
- Package mips_ctrl_pkg holds the state encodings, opcode constants, ula_operation codes (ADD/SUB/FUNCT), alu_src_b codes and pc_source codes.
- Sub-module mips_ctrl_decode is the combinational state-to-control-word decoder. The top level holds the state register, next-state logic and the sticky illegal_op flop.

## Test plan
- Reset held 2 cycles, then released with mem_ready=1 and opcode=0x00 -> state sequence 0,1,6,7,0. reg_write=1 and reg_dst=1 only in state 7. instr_done pulses once.
- LW (0x23) with mem_ready=0 for 2 cycles in MEM_READ -> sequence 0,1,2,3,3,3,4,0. mem_read=1 and i_or_d=1 throughout state 3. mem_to_reg=1 in state 4.
- BEQ (0x04) -> 3 cycles. In state 8: pc_write_cond=1, ula_operation=01, pc_source=01, pc_write=0.
- FETCH with mem_ready=0 for 3 cycles -> ir_write=pc_write=0 while waiting, both 1 on the ready cycle, then DECODE.
- Opcode 0x3F -> HALT (15). illegal_op=1 and stays there despite further opcodes; a reset pulse returns the FSM to FETCH with illegal_op=0.
- Opcode 0x02 -> with MIPS_CTRL_JUMP_EN: states 0,1,9, with pc_write=1 and pc_source=10 in state 9. Without it: HALT.
